// File: rtl/alu_cmd_pkg.sv
// Shared types for the ALU command responder.
//   alu_op_e    : 4-bit opcode set, all 16 codes defined
//   FLAG_*      : bit positions inside the 4-bit response flag field
//   alu_state_e : execute FSM states
//   alu_rsp_t   : one response FIFO entry {result, flags, tag}
// The response struct is sized from ALU_WIDTH / ALU_TAG_W. The top-level
// WIDTH / TAG_W parameters default to these values and must stay equal to them.
package alu_cmd_pkg;

    localparam int ALU_WIDTH = 8;
    localparam int ALU_TAG_W = 4;

    localparam int FLAG_C  = 0;
    localparam int FLAG_V  = 1;
    localparam int FLAG_Z  = 2;
    localparam int FLAG_DZ = 3;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_SLL  = 4'd4,
        OP_SRL  = 4'd5,
        OP_ROL  = 4'd6,
        OP_ROR  = 4'd7,
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_XOR  = 4'd10,
        OP_NOR  = 4'd11,
        OP_NAND = 4'd12,
        OP_XNOR = 4'd13,
        OP_AGTB = 4'd14,
        OP_AEQB = 4'd15
    } alu_op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_DIVIDE = 1'b1
    } alu_state_e;

    typedef struct packed {
        logic [2*ALU_WIDTH-1:0] result;
        logic [3:0]             flags;
        logic [ALU_TAG_W-1:0]   tag;
    } alu_rsp_t;

endpackage

// File: rtl/alu_resp_fifo.sv
// Synchronous response FIFO holding alu_rsp_t entries.
//   clk, reset     : clock, async active-low reset (empties the FIFO)
//   push_i/data_i  : write an entry (ignored when full unless popping too)
//   pop_i          : drop the head entry (ignored when empty)
//   data_o         : head entry, valid whenever empty_o is low
//   count_o        : occupancy 0..DEPTH
//   full_o/empty_o : occupancy flags
module alu_resp_fifo
    import alu_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  alu_rsp_t               data_i,
    input  logic                   pop_i,
    output alu_rsp_t               data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    alu_rsp_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot in the same edge, so a full FIFO can still take a push.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/alu_cmd_responder.sv
// Responder end of the ALU command interface.
//   clk, reset            : clock, async active-low reset
//   req_valid/req_ready   : request handshake; req_op/req_a/req_b/req_tag captured on accept
//   rsp_valid/rsp_ready   : response handshake; rsp_result/rsp_flags/rsp_tag show the FIFO head
//   busy                  : divide running or responses still queued
// Single-cycle ops are pushed into the response FIFO at the accepting edge.
// DIV with a non-zero divisor runs a restoring divider, one quotient bit per cycle.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | accepting requests while the FIFO has space
//   ST_DIVIDE | iterating the divider, requests held off, pushes on last step
module alu_cmd_responder
    import alu_cmd_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4,
    parameter int TAG_W = ALU_TAG_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         req_op,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_result,
    output logic [3:0]         rsp_flags,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic               busy
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    alu_state_e       state_q;
    logic             run_q;
    logic [WIDTH-1:0] div_rem_q;
    logic [WIDTH-1:0] div_quo_q;
    logic [WIDTH-1:0] div_b_q;
    logic [TAG_W-1:0] div_tag_q;
    logic [CNT_W-1:0] div_cnt_q;

    logic               accept;
    logic               start_div;
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [2*WIDTH-1:0] mul_full;
    logic [2*WIDTH-1:0] rot_l;
    logic [2*WIDTH-1:0] rot_r;
    logic [SH_W-1:0]    sh_amt;
    logic [2*WIDTH-1:0] exe_result;
    logic [3:0]         exe_flags;

    logic [WIDTH:0]     div_part;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_d;
    logic [WIDTH-1:0]   div_quo_d;
    logic               div_last;

    logic                  fifo_push;
    alu_rsp_t              fifo_din;
    alu_rsp_t              fifo_head;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    // run_q keeps req_ready low while reset is asserted.
    assign req_ready = run_q && (state_q == ST_IDLE) && !fifo_full;
    assign accept    = req_valid && req_ready;
    assign start_div = accept && (alu_op_e'(req_op) == OP_DIV) && (req_b != '0);

    always_comb begin
        add_full   = {1'b0, req_a} + {1'b0, req_b};
        sub_full   = {1'b0, req_a} - {1'b0, req_b};
        mul_full   = {{WIDTH{1'b0}}, req_a} * {{WIDTH{1'b0}}, req_b};
        sh_amt     = req_b[SH_W-1:0];
        rot_l      = {req_a, req_a} << sh_amt;
        rot_r      = {req_a, req_a} >> sh_amt;
        exe_result = '0;
        exe_flags  = '0;
        case (alu_op_e'(req_op))
            OP_ADD: begin
                exe_result        = {{(WIDTH-1){1'b0}}, add_full};
                exe_flags[FLAG_C] = add_full[WIDTH];
                exe_flags[FLAG_V] = (req_a[WIDTH-1] == req_b[WIDTH-1]) &&
                                    (add_full[WIDTH-1] != req_a[WIDTH-1]);
            end
            OP_SUB: begin
                exe_result        = {{WIDTH{1'b0}}, sub_full[WIDTH-1:0]};
                exe_flags[FLAG_C] = sub_full[WIDTH];
                exe_flags[FLAG_V] = (req_a[WIDTH-1] != req_b[WIDTH-1]) &&
                                    (sub_full[WIDTH-1] != req_a[WIDTH-1]);
            end
            OP_MUL:  exe_result = mul_full;
            OP_DIV: begin
                // Only the divide-by-zero case is pushed from here.
                if (req_b == '0) begin
                    exe_result         = {req_a, {WIDTH{1'b1}}};
                    exe_flags[FLAG_DZ] = 1'b1;
                end
            end
            OP_SLL:  exe_result = {{WIDTH{1'b0}}, req_a << sh_amt};
            OP_SRL:  exe_result = {{WIDTH{1'b0}}, req_a >> sh_amt};
            OP_ROL:  exe_result = {{WIDTH{1'b0}}, rot_l[2*WIDTH-1:WIDTH]};
            OP_ROR:  exe_result = {{WIDTH{1'b0}}, rot_r[WIDTH-1:0]};
            OP_AND:  exe_result = {{WIDTH{1'b0}}, req_a & req_b};
            OP_OR:   exe_result = {{WIDTH{1'b0}}, req_a | req_b};
            OP_XOR:  exe_result = {{WIDTH{1'b0}}, req_a ^ req_b};
            OP_NOR:  exe_result = {{WIDTH{1'b0}}, ~(req_a | req_b)};
            OP_NAND: exe_result = {{WIDTH{1'b0}}, ~(req_a & req_b)};
            OP_XNOR: exe_result = {{WIDTH{1'b0}}, ~(req_a ^ req_b)};
            OP_AGTB: exe_result = {{(2*WIDTH-1){1'b0}}, (req_a > req_b)};
            OP_AEQB: exe_result = {{(2*WIDTH-1){1'b0}}, (req_a == req_b)};
            default: exe_result = '0;
        endcase
        exe_flags[FLAG_Z] = (exe_result == '0);
    end

    // Restoring step: quotient register shifts the dividend out MSB-first
    // while quotient bits shift in at the bottom.
    always_comb begin
        div_part  = {div_rem_q, div_quo_q[WIDTH-1]};
        div_diff  = div_part - {1'b0, div_b_q};
        div_ge    = (div_part >= {1'b0, div_b_q});
        div_rem_d = div_ge ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0];
        div_quo_d = {div_quo_q[WIDTH-2:0], div_ge};
        div_last  = (div_cnt_q == CNT_W'(1));
    end

    always_comb begin
        fifo_push = 1'b0;
        fifo_din  = '0;
        if ((state_q == ST_DIVIDE) && div_last) begin
            fifo_push                = 1'b1;
            fifo_din.result          = {div_rem_d, div_quo_d};
            fifo_din.flags[FLAG_Z]   = ({div_rem_d, div_quo_d} == '0);
            fifo_din.tag             = div_tag_q;
        end else if (accept && !start_div) begin
            fifo_push       = 1'b1;
            fifo_din.result = exe_result;
            fifo_din.flags  = exe_flags;
            fifo_din.tag    = req_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            run_q     <= 1'b0;
            div_rem_q <= '0;
            div_quo_q <= '0;
            div_b_q   <= '0;
            div_tag_q <= '0;
            div_cnt_q <= '0;
        end else begin
            run_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (start_div) begin
                        state_q   <= ST_DIVIDE;
                        div_rem_q <= '0;
                        div_quo_q <= req_a;
                        div_b_q   <= req_b;
                        div_tag_q <= req_tag;
                        div_cnt_q <= CNT_W'(WIDTH);
                    end
                end
                ST_DIVIDE: begin
                    div_rem_q <= div_rem_d;
                    div_quo_q <= div_quo_d;
                    div_cnt_q <= div_cnt_q - 1'b1;
                    if (div_last) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    alu_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .data_i  (fifo_din),
        .pop_i   (rsp_ready),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Head storage is not reset, so outputs are forced to zero while empty.
    assign rsp_valid  = !fifo_empty;
    assign rsp_result = fifo_empty ? '0 : fifo_head.result;
    assign rsp_flags  = fifo_empty ? '0 : fifo_head.flags;
    assign rsp_tag    = fifo_empty ? '0 : fifo_head.tag;
    assign busy       = (state_q == ST_DIVIDE) || (fifo_count != '0);

endmodule

// File: tb/tb_alu_cmd_responder.sv
module tb_alu_cmd_responder;

    localparam int W  = 8;
    localparam int NV = 17;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [3:0]   req_tag;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [15:0]  rsp_result;
    logic [3:0]   rsp_flags;
    logic [3:0]   rsp_tag;
    logic         busy;

    int checks = 0;
    int errors = 0;

    alu_cmd_responder #(.WIDTH(8), .DEPTH(4), .TAG_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_tag    (rsp_tag),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  tag;
        logic [15:0] res;
        logic [3:0]  flg;
    } vec_t;

    vec_t vecs [NV];
    logic [23:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation definitions.
    function automatic logic [19:0] model(input int op, input int a, input int b);
        int r, f, amt, sa, sb, s;
        amt = b % 8;
        sa  = (a > 127) ? a - 256 : a;
        sb  = (b > 127) ? b - 256 : b;
        r   = 0;
        f   = 0;
        case (op)
            0: begin
                r = a + b;
                if (r > 255) f = f | 1;
                s = sa + sb;
                if (s > 127 || s < -128) f = f | 2;
            end
            1: begin
                r = (a - b) & 255;
                if (a < b) f = f | 1;
                s = sa - sb;
                if (s > 127 || s < -128) f = f | 2;
            end
            2: r = a * b;
            3: begin
                if (b == 0) begin
                    r = a * 256 + 255;
                    f = f | 8;
                end else begin
                    r = (a % b) * 256 + (a / b);
                end
            end
            4:  r = (a << amt) & 255;
            5:  r = a >> amt;
            6:  r = ((a << amt) | (a >> (8 - amt))) & 255;
            7:  r = ((a >> amt) | (a << (8 - amt))) & 255;
            8:  r = a & b;
            9:  r = a | b;
            10: r = a ^ b;
            11: r = (~(a | b)) & 255;
            12: r = (~(a & b)) & 255;
            13: r = (~(a ^ b)) & 255;
            14: r = (a > b) ? 1 : 0;
            default: r = (a == b) ? 1 : 0;
        endcase
        if (r == 0) f = f | 4;
        return {r[15:0], f[3:0]};
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        int rlow;
        int exp_lat;
        exp_lat = (v.op == 4'd3 && v.b != 8'd0) ? 9 : 1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        req_tag   = v.tag;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        chk($sformatf("v%0d_ready", idx), 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat  = 0;
        rlow = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!req_ready) rlow++;
        end while (!rsp_valid && lat < 30);
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(exp_lat));
        if (exp_lat == 9) chk($sformatf("v%0d_ready_low", idx), 32'(rlow), 32'd8);
        chk($sformatf("v%0d_result", idx), 32'(rsp_result), 32'(v.res));
        chk($sformatf("v%0d_flags", idx), 32'(rsp_flags), 32'(v.flg));
        chk($sformatf("v%0d_tag", idx), 32'(rsp_tag), 32'(v.tag));
        chk($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_drained", idx), 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int got;
        int cyc;
        int stale;
        bit acc4;
        logic [23:0] e;

        vecs[0]  = {4'd0,  8'hF0, 8'h20, 4'd3,  16'h0110, 4'b0001};
        vecs[1]  = {4'd0,  8'h7F, 8'h01, 4'd5,  16'h0080, 4'b0010};
        vecs[2]  = {4'd1,  8'h05, 8'h07, 4'd6,  16'h00FE, 4'b0001};
        vecs[3]  = {4'd1,  8'h80, 8'h01, 4'd7,  16'h007F, 4'b0010};
        vecs[4]  = {4'd15, 8'h33, 8'h33, 4'd8,  16'h0001, 4'b0000};
        vecs[5]  = {4'd14, 8'h10, 8'h20, 4'd9,  16'h0000, 4'b0100};
        vecs[6]  = {4'd3,  8'd200, 8'd7, 4'd10, 16'h041C, 4'b0000};
        vecs[7]  = {4'd3,  8'h55, 8'h00, 4'd11, 16'h55FF, 4'b1000};
        vecs[8]  = {4'd6,  8'h81, 8'h01, 4'd12, 16'h0003, 4'b0000};
        vecs[9]  = {4'd7,  8'h81, 8'h09, 4'd13, 16'h00C0, 4'b0000};
        vecs[10] = {4'd2,  8'hFF, 8'hFF, 4'd14, 16'hFE01, 4'b0000};
        vecs[11] = {4'd4,  8'h01, 8'h0F, 4'd1,  16'h0080, 4'b0000};
        vecs[12] = {4'd5,  8'h80, 8'h07, 4'd2,  16'h0001, 4'b0000};
        vecs[13] = {4'd11, 8'h00, 8'h00, 4'd4,  16'h00FF, 4'b0000};
        vecs[14] = {4'd3,  8'h00, 8'h05, 4'd15, 16'h0000, 4'b0100};
        vecs[15] = {4'd8,  8'hF0, 8'h0F, 4'd0,  16'h0000, 4'b0100};
        vecs[16] = {4'd13, 8'hA5, 8'hA5, 4'd1,  16'h00FF, 4'b0000};

        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;

        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Backpressure: fill the FIFO, fifth request must stall until a pop.
        rsp_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            req_op    = 4'd10;
            req_a     = 8'(t * 17);
            req_b     = 8'h0F;
            req_tag   = 4'(t);
            req_valid = 1'b1;
            chk($sformatf("full_fill%0d_ready", t), 32'(req_ready), 32'd1);
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        req_tag = 4'd4;
        req_a   = 8'h44;
        chk("full_ready_low", 32'(req_ready), 32'd0);
        chk("full_head_tag", 32'(rsp_tag), 32'd0);
        repeat (2) @(negedge clk);
        chk("full_ready_held", 32'(req_ready), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        rsp_ready = 1'b1;
        got  = 0;
        cyc  = 0;
        acc4 = 1'b0;
        while (got < 5 && cyc < 30) begin
            if (req_valid && req_ready) acc4 = 1'b1;
            if (rsp_valid) begin
                chk($sformatf("full_order%0d", got), 32'(rsp_tag), 32'(got));
                chk($sformatf("full_res%0d", got), 32'({rsp_result, rsp_flags}),
                    32'(model(10, got * 17, 15)));
                got++;
            end
            @(posedge clk);
            #1;
            if (acc4) req_valid = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk("full_count", 32'(got), 32'd5);
        chk("full_tag4_accepted", 32'(acc4), 32'd1);
        req_valid = 1'b0;
        rsp_ready = 1'b0;

        // Reset in the middle of a divide.
        req_op    = 4'd3;
        req_a     = 8'd200;
        req_b     = 8'd7;
        req_tag   = 4'd9;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_div_busy", 32'(busy), 32'd1);
        chk("mid_div_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        chk("arst_rsp_result", 32'(rsp_result), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("arst_rel_ready", 32'(req_ready), 32'd1);
        stale = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) stale++;
        end
        chk("arst_no_stale", 32'(stale), 32'd0);

        // Random traffic against the scoreboard.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            req_valid = ($urandom_range(0, 3) != 0);
            req_op    = 4'($urandom_range(0, 15));
            req_a     = 8'($urandom_range(0, 255));
            req_b     = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            req_tag   = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (req_valid && req_ready)
                exp_q.push_back({model(int'(req_op), int'(req_a), int'(req_b)), req_tag});
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_unexpected: got tag 0x%0h with no response expected", rsp_tag);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_rsp", 32'({rsp_result, rsp_flags, rsp_tag}), 32'(e));
                end
            end
        end

        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            if (rsp_valid) begin
                e = exp_q.pop_front();
                chk("drain_rsp", 32'({rsp_result, rsp_flags, rsp_tag}), 32'(e));
            end
            @(negedge clk);
            cyc++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_responder.md
Name: alu_cmd_responder

Overview:
- Responder end of the ALU operation interface: accepts ALU commands (opcode, operands A/B, tag) over a valid/ready request channel.
- Executes each command: single-cycle for most ops, iterative for divide.
- Returns results, flags and tag in order over a valid/ready response channel with backpressure.
- Sits behind the ALU stimulus path as the RTL counterpart of the command initiator. It replaces direct operand poking with a handshaked, buffered transaction port.

Parameters:
- WIDTH, 8, operand width in bits (power of 2, ≥4).
- DEPTH, 4, response FIFO entries (power of 2, ≥2).
- TAG_W, 4, request/response tag width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_op  in  4  opcode (see Behaviour).
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_tag  in  TAG_W  transaction ID, echoed back on the response.
- rsp_valid  out  1  response at FIFO head.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  2*WIDTH  result, zero-extended.
- rsp_flags  out  4  [0]=C (carry/borrow), [1]=V (signed overflow), [2]=Z (rsp_result==0), [3]=DZ (divide by zero).
- rsp_tag  out  TAG_W  echoed tag.
- busy  out  1  divide in progress or FIFO non-empty.

Behaviour:
- Opcodes 0–15: ADD, SUB, MUL, DIV, SLL, SRL, ROL, ROR, AND, OR, XOR, NOR, NAND, XNOR, AGTB, AEQB.
- Reset (reset=0, asynchronous): FSM to IDLE, FIFO emptied, any divide aborted. req_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_tag=0, busy=0.
- req_ready=1 in the first cycle after reset release.
- FSM has two states, IDLE and DIVIDE.
- req_ready = (state==IDLE) && (fifo_count<DEPTH). It is a registered/state-derived signal with no combinational path from rsp_ready.
- Accept = req_valid && req_ready at a rising edge. Operands, op and tag are captured at that edge.
- Non-DIV ops: result pushed into the FIFO at the accepting edge. rsp_valid rises the following cycle if the FIFO was empty (latency 1).
- ADD: {0, carry, sum}. C=carry out, V=signed overflow.
- SUB: A−B, low WIDTH bits zero-extended. C=borrow (A<B unsigned), V=signed overflow.
- MUL: full 2*WIDTH unsigned product. C=V=0.
- SLL/SRL/ROL/ROR: shift/rotate amount = b[$clog2(WIDTH)-1:0], so upper bits of B are ignored. Result zero-extended.
- Logic ops (AND…XNOR): bitwise on WIDTH bits, zero-extended.
- AGTB: result 1 if A>B unsigned, else 0. AEQB: result 1 if A==B, else 0.
- DIV, B≠0: enter DIVIDE. Restoring unsigned division, one quotient bit per cycle, WIDTH cycles. Push {remainder, quotient} at the final edge, then return to IDLE. req_ready=0 throughout DIVIDE.
- DIV, B==0: no DIVIDE entry. Pushed like a single-cycle op with quotient=all ones, remainder=A, DZ=1.
- DIV latency: rsp_valid WIDTH+1 cycles after the accepting edge.
- Z is computed for every op. Unused flags are 0.
- FIFO behaviour:
  - rsp_* always reflect the head entry. Pop when rsp_valid && rsp_ready.
  - Push and pop in the same cycle are allowed at any count, including full (a pop that frees space takes effect next cycle).
  - Pointers wrap modulo DEPTH. Responses are strictly in acceptance order.
- Unknown behaviour is not permitted: all 16 opcodes are defined.

Decomposition:
- Package alu_cmd_pkg: opcode enum (alu_op_e), flag bit index constants (FLAG_C, FLAG_V, FLAG_Z, FLAG_DZ), FSM state enum, and a packed response struct {result, flags, tag}.
- One sub-module, alu_resp_fifo: parameterised synchronous FIFO of the response struct with count, full and empty outputs.
- The execute datapath and divider stay in the top module.

Test Plan:
- ADD A=0xF0 B=0x20 tag=3 → rsp_result=0x0110, C=1 V=0 Z=0, tag=3, rsp_valid one cycle after accept. ADD 0x7F+0x01 → 0x0080, V=1 C=0.
- SUB A=0x05 B=0x07 → 0x00FE, C=1 V=0. AEQB 0x33,0x33 → 0x0001. AGTB 0x10,0x20 → 0x0000, Z=1.
- DIV A=200 B=7 → 0x041C (rem 4, quot 28), rsp_valid 9 cycles after accept, req_ready low 8 cycles. DIV A=0x55 B=0 → 0x55FF, DZ=1, latency 1.
- ROL A=0x81 B=0x01 → 0x0003. ROR A=0x81 B=0x09 (amount 1) → 0x00C0. MUL 0xFF×0xFF → 0xFE01.
- rsp_ready held 0, issue 5 XOR commands tags 0–4 → 4 accepted, req_ready=0 while full. Release rsp_ready → tags 0,1,2,3 in order, then tag 4 accepted.
- Assert reset 3 cycles into a DIV → rsp_valid, busy and req_ready drop immediately. After release, no stale response appears and req_ready=1 next cycle.
